// File: rtl/sr_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, access sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sr_lsu_pkg;

    // RISC-V load/store width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_HU = 3'b101;  // LHU

    // Access sizes in bytes
    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    // Transaction FSM
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/sr_lsu_check.sv
// Request decoder: funct3 legality, alignment and RAM range check plus op/sign decode.
// Latency: purely combinational.
// Backpressure: none; evaluated on whatever request sits on the inputs.
module sr_lsu_check
    import sr_lsu_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    output logic        err_o,
    output logic        op_word_o,
    output logic        op_half_o,
    output logic        op_byte_o,
    output logic        sign_o
);

    // Range compare is done on 33 bits so addresses near 2^32 cannot wrap into range
    localparam logic [32:0] DEPTH_W = 33'(DEPTH);

    logic        illegal;
    logic        misalign;
    logic        out_of_range;
    logic [2:0]  size;
    logic [32:0] last_byte;

    // Decode width/sign and flag codes that are not valid for this direction
    always_comb begin
        illegal   = 1'b0;
        op_word_o = 1'b0;
        op_half_o = 1'b0;
        op_byte_o = 1'b0;
        sign_o    = 1'b0;
        size      = SZ_BYTE;
        case (funct3_i)
            F3_B: begin
                op_byte_o = 1'b1;
                sign_o    = ~we_i;
                size      = SZ_BYTE;
            end
            F3_H: begin
                op_half_o = 1'b1;
                sign_o    = ~we_i;
                size      = SZ_HALF;
            end
            F3_W: begin
                op_word_o = 1'b1;
                size      = SZ_WORD;
            end
            F3_BU: begin
                // unsigned variants exist only for loads
                illegal   = we_i;
                op_byte_o = ~we_i;
                size      = SZ_BYTE;
            end
            F3_HU: begin
                illegal   = we_i;
                op_half_o = ~we_i;
                size      = SZ_HALF;
            end
            default: begin
                illegal   = 1'b1;
            end
        endcase
    end

    // Alignment and range of the last byte touched by the access
    always_comb begin
        misalign     = (op_half_o && addr_i[0]) ||
                       (op_word_o && (addr_i[1:0] != 2'b00));
        last_byte    = {1'b0, addr_i} + 33'(size) - 33'd1;
        out_of_range = (last_byte >= DEPTH_W);
        err_o        = illegal || misalign || out_of_range;
    end

endmodule

// File: rtl/sr_lsu.sv
// Load/store unit bridging a valid/ready core port to a combinational-read data RAM.
// Latency: good request responds 2 cycles after handshake, rejected request after 1.
// Backpressure: one transaction in flight; req_ready low until the response is taken.
module sr_lsu
    import sr_lsu_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst,
    // core request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    // core response
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // data RAM
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_sign,
    output logic        mem_op_word,
    output logic        mem_op_half,
    output logic        mem_op_byte,
    input  logic [31:0] mem_rdata,
    // status
    output logic [7:0]  err_cnt
);

    state_t      state_q;
    logic        we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_we_q;
    logic        mem_sign_q;
    logic        op_word_q;
    logic        op_half_q;
    logic        op_byte_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [7:0]  err_cnt_q;
    logic [7:0]  err_cnt_d;

    logic        chk_err;
    logic        chk_op_word;
    logic        chk_op_half;
    logic        chk_op_byte;
    logic        chk_sign;
    logic        req_fire;

    sr_lsu_check #(
        .DEPTH (DEPTH)
    ) u_check (
        .we_i      (req_we),
        .funct3_i  (req_funct3),
        .addr_i    (req_addr),
        .err_o     (chk_err),
        .op_word_o (chk_op_word),
        .op_half_o (chk_op_half),
        .op_byte_o (chk_op_byte),
        .sign_o    (chk_sign)
    );

    // Accept only from IDLE, so a response handshake can never overlap a new request
    assign req_ready = (state_q == ST_IDLE);
    assign req_fire  = req_valid && req_ready;

    // Saturating error counter next value
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Transaction FSM with registered RAM controls and response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_sign_q  <= 1'b0;
            op_word_q   <= 1'b0;
            op_half_q   <= 1'b0;
            op_byte_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_fire) begin
                        we_q        <= req_we;
                        mem_addr_q  <= req_addr;
                        mem_wdata_q <= req_wdata;
                        if (chk_err) begin
                            // rejected: skip the RAM entirely
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            err_cnt_q   <= err_cnt_d;
                        end else begin
                            state_q     <= ST_ACCESS;
                            mem_we_q    <= req_we;
                            mem_sign_q  <= chk_sign;
                            op_word_q   <= chk_op_word;
                            op_half_q   <= chk_op_half;
                            op_byte_q   <= chk_op_byte;
                        end
                    end
                end
                ST_ACCESS: begin
                    // RAM read data is already extended by the RAM per op/sign
                    state_q     <= ST_RESP;
                    mem_we_q    <= 1'b0;
                    mem_sign_q  <= 1'b0;
                    op_word_q   <= 1'b0;
                    op_half_q   <= 1'b0;
                    op_byte_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= we_q ? 32'd0 : mem_rdata;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_sign    = mem_sign_q;
    assign mem_op_word = op_word_q;
    assign mem_op_half = op_half_q;
    assign mem_op_byte = op_byte_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign err_cnt     = err_cnt_q;

endmodule
